// File: rtl/dbg_capture_writer.sv
// Debug capture write-side controller: arm / pre-trigger / trigger / post-trigger
// capture of a sample stream into a circular dual-port BRAM buffer.
module dbg_capture_writer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic              din_valid,
  input  logic [WIDTH-1:0]  din,
  input  logic [AWIDTH-1:0] pre_len,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_dat,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] trig_addr,
  output logic [AWIDTH-1:0] start_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic [AWIDTH-1:0] pre_q, pre_d;
  logic [AWIDTH-1:0] rem_q, rem_d;
  logic [AWIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [AWIDTH-1:0] start_q, start_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  dat_q, dat_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [AWIDTH-1:0] pre_clamp_c;
  logic [AWIDTH-1:0] ptr_inc_c;
  logic [AWIDTH-1:0] trig_src_c;
  logic [AWIDTH-1:0] start_calc_c;
  logic              write_c;
  logic              finish_c;

  // Clamped pre-trigger length, wrapping pointer increment and oldest-sample address.
  always_comb begin
    pre_clamp_c  = (pre_len > LAST_ADDR) ? LAST_ADDR : pre_len;
    ptr_inc_c    = (ptr_q == LAST_ADDR) ? '0 : ptr_q + AWIDTH'(1);
    // With no post-trigger samples the trigger sample is being written right now.
    trig_src_c   = (state_q == S_POST) ? trig_addr_q : ptr_q;
    start_calc_c = (trig_src_c >= pre_q) ? (trig_src_c - pre_q)
                 : AWIDTH'({1'b0, trig_src_c} + DEPTH_W - {1'b0, pre_q});
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pre_d       = pre_q;
    rem_d       = rem_q;
    trig_addr_d = trig_addr_q;
    start_d     = start_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    we_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    write_c     = 1'b0;
    finish_c    = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            ptr_d   = '0;
            pre_d   = pre_clamp_c;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = (pre_clamp_c == '0) ? S_WAIT : S_FILL;
          end
        end
        S_FILL: begin
          if (din_valid) begin
            write_c = 1'b1;
            if (ptr_q == pre_q - AWIDTH'(1)) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (din_valid) begin
            write_c = 1'b1;
            if (trig) begin
              trig_addr_d = ptr_q;
              rem_d       = LAST_ADDR - pre_q;
              if (pre_q == LAST_ADDR) finish_c = 1'b1;
              else                    state_d  = S_POST;
            end
          end
        end
        S_POST: begin
          if (din_valid) begin
            write_c = 1'b1;
            rem_d   = rem_q - AWIDTH'(1);
            if (rem_q == AWIDTH'(1)) finish_c = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (write_c) begin
        we_d   = 1'b1;
        addr_d = ptr_q;
        dat_d  = din;
        ptr_d  = ptr_inc_c;
      end

      if (finish_c) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        start_d = start_calc_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      pre_q       <= '0;
      rem_q       <= '0;
      trig_addr_q <= '0;
      start_q     <= '0;
      addr_q      <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pre_q       <= pre_d;
      rem_q       <= rem_d;
      trig_addr_q <= trig_addr_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_dat    = dat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_q;

endmodule

// File: tb/tb_dbg_capture_writer.sv
// Scoreboard bench for dbg_capture_writer: a 16-deep and a 12-deep instance share
// one stimulus stream; a sample-counting model predicts every cycle's outputs.
module tb_dbg_capture_writer;

  localparam int NDUT = 2;
  localparam int AW   = 4;

  typedef struct {
    int   dut;
    logic we;
    int   addr;
    int   dat;
    logic busy;
    logic done;
    int   ta;
    int   sa;
    logic chk_ptrs;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n, arm, abort, trig, din_valid;
  logic [7:0]    din;
  logic [AW-1:0] pre_len;

  logic          we_w   [NDUT];
  logic [AW-1:0] addr_w [NDUT];
  logic [7:0]    dat_w  [NDUT];
  logic          busy_w [NDUT];
  logic          done_w [NDUT];
  logic [AW-1:0] ta_w   [NDUT];
  logic [AW-1:0] sa_w   [NDUT];

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: capturing flag, samples written, trigger seen, post count, latched P.
  bit   m_cap   [NDUT];
  bit   m_done  [NDUT];
  bit   m_tseen [NDUT];
  int   m_w     [NDUT];
  int   m_after [NDUT];
  int   m_p     [NDUT];
  int   m_ta    [NDUT];
  int   m_sa    [NDUT];
  int   m_la    [NDUT];
  int   m_ld    [NDUT];

  always #5 clk = ~clk;

  dbg_capture_writer #(.WIDTH(8), .DEPTH(16)) u_d16 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .trig(trig),
    .din_valid(din_valid), .din(din), .pre_len(pre_len),
    .ram_we(we_w[0]), .ram_addr(addr_w[0]), .ram_dat(dat_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .trig_addr(ta_w[0]), .start_addr(sa_w[0])
  );

  dbg_capture_writer #(.WIDTH(8), .DEPTH(12)) u_d12 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .trig(trig),
    .din_valid(din_valid), .din(din), .pre_len(pre_len),
    .ram_we(we_w[1]), .ram_addr(addr_w[1]), .ram_dat(dat_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .trig_addr(ta_w[1]), .start_addr(sa_w[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic logic [63:0] bitm(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s depth%0d t=%0t: got %0h want %0h", name, dep(k), $time, act, want);
    end
  endtask

  // Predicts the outputs after the coming edge from the capture rules.
  task automatic model_step(input int k);
    exp_t e;
    int   d;
    int   a;
    d = dep(k);
    e.dut = k;
    e.we = 1'b0;
    e.chk_ptrs = 1'b0;
    if (!reset_n) begin
      m_cap[k] = 0; m_done[k] = 0; m_ta[k] = 0; m_sa[k] = 0; m_la[k] = 0; m_ld[k] = 0;
      e.chk_ptrs = 1'b1;
    end else if (abort) begin
      m_cap[k] = 0; m_done[k] = 0;
    end else if (!m_cap[k]) begin
      if (arm) begin
        m_cap[k] = 1; m_done[k] = 0; m_tseen[k] = 0; m_w[k] = 0; m_after[k] = 0;
        m_p[k] = (int'(pre_len) > d - 1) ? d - 1 : int'(pre_len);
      end
    end else if (din_valid) begin
      a = m_w[k] % d;
      e.we = 1'b1;
      m_la[k] = a;
      m_ld[k] = int'(din);
      if (!m_tseen[k]) begin
        if (m_w[k] >= m_p[k] && trig) begin
          m_tseen[k] = 1;
          m_ta[k] = a;
        end
      end else begin
        m_after[k]++;
      end
      m_w[k]++;
      if (m_tseen[k] && m_after[k] == d - 1 - m_p[k]) begin
        m_cap[k] = 0;
        m_done[k] = 1;
        m_sa[k] = (m_ta[k] - m_p[k] + d) % d;
      end
    end
    e.addr = m_la[k];
    e.dat  = m_ld[k];
    e.busy = m_cap[k];
    e.done = m_done[k];
    e.ta   = m_ta[k];
    e.sa   = m_sa[k];
    if (m_done[k]) e.chk_ptrs = 1'b1;
    expq.push_back(e);
  endtask

  task automatic drive(input logic a, input logic ab, input logic t, input logic v,
                       input logic [7:0] d, input logic [AW-1:0] p, input logic rn);
    arm = a; abort = ab; trig = t; din_valid = v; din = d; pre_len = p; reset_n = rn;
    for (int k = 0; k < NDUT; k++) model_step(k);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0, 8'($urandom), AW'($urandom), 1'b1);
  endtask

  task automatic capture(input logic [AW-1:0] pre, input int n, input logic [63:0] tmask,
                         input int abort_at, input int rst_at, input int gap_pct, input int chaos_pct);
    logic ca;
    logic cb;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, pre, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < gap_pct) idle(1);
      ca = int'($urandom_range(199)) < chaos_pct;
      cb = int'($urandom_range(399)) < chaos_pct;
      drive(ca, (i == abort_at) || cb, tmask[i], 1'b1, 8'(i), AW'($urandom), (i == rst_at) ? 1'b0 : 1'b1);
    end
  endtask

  // Monitor: every cycle, pop one expectation per instance and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_underflow t=%0t: got empty queue want entry", $time);
        end else begin
          e = expq.pop_front();
          chk("ram_we",   e.dut, 32'(we_w[e.dut]),   32'(e.we));
          chk("ram_addr", e.dut, 32'(addr_w[e.dut]), 32'(e.addr));
          chk("ram_dat",  e.dut, 32'(dat_w[e.dut]),  32'(e.dat));
          chk("busy",     e.dut, 32'(busy_w[e.dut]), 32'(e.busy));
          chk("done",     e.dut, 32'(done_w[e.dut]), 32'(e.done));
          if (e.chk_ptrs) begin
            chk("trig_addr",  e.dut, 32'(ta_w[e.dut]), 32'(e.ta));
            chk("start_addr", e.dut, 32'(sa_w[e.dut]), 32'(e.sa));
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] tm;
    arm = 1'b0; abort = 1'b0; trig = 1'b0; din_valid = 1'b0; din = '0; pre_len = '0; reset_n = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    idle(2);

    // Basic capture: trigger on sample 10, pre 4.
    capture(4'd4, 30, bitm(10), -1, -1, 0, 0);
    idle(3);
    // Early triggers during fill are ignored; restart directly from done.
    capture(4'd4, 30, bitm(1) | bitm(2) | bitm(3) | bitm(7), -1, -1, 0, 0);
    idle(2);
    // No pre-trigger history: trigger on the very first sample.
    capture(4'd0, 20, bitm(0), -1, -1, 20, 0);
    idle(2);
    // Maximum pre length with trigger held high for many samples.
    tm = bitm(41) - bitm(30);
    capture(4'd15, 50, tm, -1, -1, 0, 0);
    idle(2);
    // Abort during post-trigger, then abort together with arm.
    capture(4'd2, 30, bitm(5), 10, -1, 0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 4'd3, 1'b1);
    idle(2);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 4'd1, 1'b1);
    // Wrapping capture with trigger on sample 20, then reset mid post-trigger.
    capture(4'd3, 40, bitm(20), -1, -1, 0, 0);
    idle(2);
    capture(4'd3, 40, bitm(20), -1, 25, 0, 0);
    idle(3);

    // Randomized captures with gaps, stray arms/aborts and changing pre_len.
    for (int r = 0; r < 25; r++) begin
      if (r % 2 == 1) tm = {$urandom, $urandom} & {$urandom, $urandom};
      else            tm = bitm(int'($urandom_range(59)));
      capture(AW'($urandom), int'($urandom_range(60, 5)), tm, -1, -1, 30, 4);
      idle(int'($urandom_range(3)));
    end
    idle(2);

    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
